bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 156 +++++++++++++++
 tb/tb_bit_serializer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one-word holding buffer feeding an MSB-first shifter.
// Optional even-parity bit after the LSB when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             C,
    output logic             busy,
    output logic             frame_start
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               busy_q, busy_d;
    logic               fs_q, fs_d;
`ifdef SER_PARITY_EN
    logic               par_q, par_d;
`endif
    logic               load;
    logic               accept;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        busy_d      = busy_q;
        fs_d        = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        accept      = in_valid && in_ready_q;

        // in_ready_q is high only while the buffer is empty, so accept and load never coincide
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                c_d    = 1'b0;
                busy_d = 1'b0;
                load   = hold_full_q;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    c_d     = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
                    c_d     = par_q;
`else
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        c_d     = 1'b0;
                        busy_d  = 1'b0;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    c_d     = 1'b0;
                    busy_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                c_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // MSB goes straight to C; the shifter keeps the remaining WIDTH-1 bits
        if (load) begin
            state_d     = SHIFT;
            c_d         = hold_q[WIDTH-1];
            shreg_d     = hold_q << 1;
            cnt_d       = CNT_W'(WIDTH - 1);
            busy_d      = 1'b1;
            fs_d        = 1'b1;
            hold_full_d = 1'b0;
`ifdef SER_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        in_ready_d = !hold_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
            shreg_q     <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            busy_q      <= 1'b0;
            fs_q        <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            in_ready_q  <= in_ready_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            busy_q      <= busy_d;
            fs_q        <= fs_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign C           = c_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=8); parity expectations follow SER_PARITY_EN.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       C;
    logic       busy;
    logic       frame_start;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SER_PARITY_EN
    localparam int FL = 9;
    localparam logic [26:0] STREAM = {8'hF0, 1'b0, 8'h0F, 1'b0, 8'h3C, 1'b0};
`else
    localparam int FL = 8;
    localparam logic [23:0] STREAM = {8'hF0, 8'h0F, 8'h3C};
`endif
    localparam int SLEN = 3 * FL;

    bit_serializer #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .C           (C),
        .busy        (busy),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ec, input logic eb, input logic ef);
        chk({tag, ".C"}, {31'd0, C}, {31'd0, ec});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, ".fs"}, {31'd0, frame_start}, {31'd0, ef});
    endtask

    // single isolated frame: accept, 8 data bits (+ parity), then idle
    task automatic run_frame(input logic [7:0] w, input logic [7:0] exp_bits,
                             input logic exp_par, input string tag);
        in_data  = w;
        in_valid = 1'b1;
        step();
        chk({tag, ".accept_rdy"}, {31'd0, in_ready}, 32'd0);
        chk_out({tag, ".pre"}, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("%s.bit%0d", tag, i), exp_bits[7-i], 1'b1, i == 0);
        end
`ifdef SER_PARITY_EN
        step();
        chk_out({tag, ".par"}, exp_par, 1'b1, 1'b0);
`else
        if (exp_par === 1'bx) $display("unexpected parity argument");
`endif
        step();
        chk_out({tag, ".end"}, 1'b0, 1'b0, 1'b0);
        chk({tag, ".end_rdy"}, {31'd0, in_ready}, 32'd1);
        $display("frame %s word=%02h done", tag, w);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #2 rst   = 1'b0;
        #1;
        // reset held with in_valid high: nothing accepted
        chk_out("rst0", 1'b0, 1'b0, 1'b0);
        chk("rst0.rdy", {31'd0, in_ready}, 32'd1);
        step();
        step();
        chk_out("rst1", 1'b0, 1'b0, 1'b0);
        chk("rst1.rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk_out("post_rst", 1'b0, 1'b0, 1'b0);
        chk("post_rst.rdy", {31'd0, in_ready}, 32'd1);
        $display("reset check done");

        run_frame(8'hA5, 8'b1010_0101, 1'b0, "a5");
        run_frame(8'h07, 8'b0000_0111, 1'b1, "07");

        // back-to-back F0, 0F, then 3C held while the buffer is full
        in_data  = 8'hF0;
        in_valid = 1'b1;
        step();
        chk("b2b.acc0", {31'd0, in_ready}, 32'd0);
        in_data = 8'h0F;
        for (int j = 0; j < SLEN; j++) begin
            logic er;
            step();
            chk_out($sformatf("b2b.j%0d", j), STREAM[SLEN-1-j], 1'b1, (j % FL) == 0);
            if (j == 0 || j == FL || j >= 2 * FL) er = 1'b1;
            else                                  er = 1'b0;
            chk($sformatf("b2b.rdy%0d", j), {31'd0, in_ready}, {31'd0, er});
            if (j == 1)      in_data  = 8'h3C;
            if (j == FL + 1) in_valid = 1'b0;
        end
        step();
        chk_out("b2b.end", 1'b0, 1'b0, 1'b0);
        $display("back-to-back stream done");

        // reset mid-frame with a second word buffered
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        chk("mid.acc", {31'd0, in_ready}, 32'd0);
        in_data = 8'h5A;
        step();
        chk_out("mid.b0", 1'b1, 1'b1, 1'b1);
        step();
        chk("mid.acc2", {31'd0, in_ready}, 32'd0);
        chk_out("mid.b1", 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk_out("mid.b2", 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_out("mid.rst", 1'b0, 1'b0, 1'b0);
        chk("mid.rst_rdy", {31'd0, in_ready}, 32'd1);
        step();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk_out($sformatf("mid.after%0d", k), 1'b0, 1'b0, 1'b0);
        end
        $display("mid-frame reset done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
